// File: rtl/robm_plant.sv
// rtl/robm_plant.sv - reactive station model driving the robm controller sensor lines
//
// Purpose: closed-loop environment for the robm station controller. Samples the
// controller commands y1..y10 on the rising clock edge and answers on the sensor
// lines x1..x12. It models the part slot, main-axis travel timer, auxiliary-tool
// timer and inspection latch, and counts finished part cycles and protocol errors.
//
// Ports:
//   clk      in   clock, commands sampled on posedge
//   rst      in   asynchronous active-high reset
//   cmd      in   [9:0]  controller commands, cmd[i] = y(i+1)
//   part_in  in   one-cycle pulse, new part presented
//   attr     in   [6:0]  part attributes {x12,x11,x10,x9,x8,x6,x5}
//   insp     in   [1:0]  inspection result {x2,x3}
//   sens     out  [11:0] sensor bus, sens[i] = x(i+1)
//   cycles   out  [7:0]  completed part cycles, wraps 255->0
//   err      out  sticky protocol error
module robm_plant #(
   parameter int MOVE_CYCLES = 4,
   parameter int AUX_CYCLES  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  cmd,
   input  logic        part_in,
   input  logic [6:0]  attr,
   input  logic [1:0]  insp,
   output logic [11:0] sens,
   output logic [7:0]  cycles,
   output logic        err
);

   typedef enum logic {S_EMPTY, S_LOADED} slot_t;
   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} move_t;
   typedef enum logic [1:0] {A_IDLE, A_BUSY, A_DONE} aux_t;

   // Counters are loaded with N-1 so the done flag appears exactly N edges
   // after the start command (N=1 finishes on the very next edge).
   localparam logic [7:0] MOVE_LOAD = 8'(MOVE_CYCLES - 1);
   localparam logic [7:0] AUX_LOAD  = 8'(AUX_CYCLES - 1);

   logic y1, y2, y3, y4, y5, y6, y9;
   logic unused_cmd;

   assign y1 = cmd[0];
   assign y2 = cmd[1];
   assign y3 = cmd[2];
   assign y4 = cmd[3];
   assign y5 = cmd[4];
   assign y6 = cmd[5];
   assign y9 = cmd[8];
   // y7, y8 and y10 have no effect on the station.
   assign unused_cmd = ^{cmd[6], cmd[7], cmd[9]};

   slot_t      slot_q;
   move_t      move_q;
   aux_t       aux_q;
   logic [7:0] move_cnt_q, aux_cnt_q;
   logic [7:0] cycles_q;
   logic [6:0] attr_q;
   logic [1:0] insp_q;
   logic       x1_q, x4_q, x7_q, err_q;
   logic       err_d;

   // ---------------- error detection ----------------
   logic illegal_cmd, slot_err, move_err;
   assign illegal_cmd = (y1 & y3) | (y4 & y2);
   // A new part while loaded is an error unless y5 empties the slot the same cycle.
   assign slot_err    = (slot_q == S_LOADED) & part_in & ~y5;
   assign move_err    = y4 & (move_q != M_DONE);
   assign err_d       = err_q | illegal_cmd | slot_err | move_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   // ---------------- part slot ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q   <= S_EMPTY;
         x1_q     <= 1'b0;
         attr_q   <= '0;
         cycles_q <= '0;
      end else begin
         case (slot_q)
            S_EMPTY: begin
               if (part_in) begin
                  slot_q <= S_LOADED;
                  x1_q   <= 1'b1;
                  attr_q <= attr;
               end
            end
            S_LOADED: begin
               if (y5) begin
                  slot_q   <= S_EMPTY;
                  x1_q     <= 1'b0;
                  attr_q   <= '0;
                  cycles_q <= cycles_q + 8'd1;
               end
            end
            default: slot_q <= S_EMPTY;
         endcase
      end
   end

   // ---------------- main axis motion ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         move_q     <= M_IDLE;
         move_cnt_q <= '0;
         x4_q       <= 1'b0;
      end else begin
         case (move_q)
            M_IDLE: begin
               if (y2) begin
                  move_q     <= M_BUSY;
                  move_cnt_q <= MOVE_LOAD;
               end
            end
            M_BUSY: begin
               if (move_cnt_q == 8'd0) begin
                  move_q <= M_DONE;
                  x4_q   <= 1'b1;
               end else begin
                  move_cnt_q <= move_cnt_q - 8'd1;
               end
            end
            M_DONE: begin
               // y2 is not re-accepted here, even alongside y4.
               if (y4) begin
                  move_q <= M_IDLE;
                  x4_q   <= 1'b0;
               end
            end
            default: move_q <= M_IDLE;
         endcase
      end
   end

   // ---------------- auxiliary tool ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aux_q     <= A_IDLE;
         aux_cnt_q <= '0;
         x7_q      <= 1'b0;
      end else begin
         case (aux_q)
            A_IDLE: begin
               if (y9) begin
                  aux_q     <= A_BUSY;
                  aux_cnt_q <= AUX_LOAD;
               end
            end
            A_BUSY: begin
               if (aux_cnt_q == 8'd0) begin
                  aux_q <= A_DONE;
                  x7_q  <= 1'b1;
               end else begin
                  aux_cnt_q <= aux_cnt_q - 8'd1;
               end
            end
            A_DONE: begin
               if (y2 & y3) begin
                  aux_q <= A_IDLE;
                  x7_q  <= 1'b0;
               end
            end
            default: aux_q <= A_IDLE;
         endcase
      end
   end

   // ---------------- inspection latch ----------------
   // A fresh y6 capture takes precedence over a same-cycle y4 clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     insp_q <= '0;
      else if (y6) insp_q <= insp;
      else if (y4) insp_q <= '0;
   end

   // ---------------- outputs ----------------
   assign sens = {attr_q[6], attr_q[5], attr_q[4], attr_q[3], attr_q[2],
                  x7_q, attr_q[1], attr_q[0], x4_q, insp_q[0], insp_q[1], x1_q};
   assign cycles = cycles_q;
   assign err    = err_q;

endmodule

// File: tb/tb_robm_plant.sv
// tb/tb_robm_plant.sv - randomized self-checking bench for robm_plant
module tb_robm_plant;

   localparam int MOVE = 4;
   localparam int AUX  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  cmd = '0;
   logic        part_in = 1'b0;
   logic [6:0]  attr = '0;
   logic [1:0]  insp = '0;
   logic [11:0] sens;
   logic [7:0]  cycles;
   logic        err;

   robm_plant #(.MOVE_CYCLES(MOVE), .AUX_CYCLES(AUX)) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .part_in(part_in), .attr(attr),
      .insp(insp), .sens(sens), .cycles(cycles), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit running = 1'b0;

   // Behavioural model: timers tracked as absolute due edges.
   int       cyc = 0;
   bit       m_loaded;
   bit [6:0] m_attr;
   int       m_cycles;
   bit       m_err;
   bit [1:0] m_insp;
   bit       m_mv_active, m_ax_active;
   int       m_mv_due, m_ax_due;

   function automatic bit mv_done_at(int n);
      return m_mv_active && (n >= m_mv_due);
   endfunction
   function automatic bit ax_done_at(int n);
      return m_ax_active && (n >= m_ax_due);
   endfunction

   task automatic model_reset();
      m_loaded = 0; m_attr = '0; m_cycles = 0; m_err = 0; m_insp = '0;
      m_mv_active = 0; m_ax_active = 0; m_mv_due = 0; m_ax_due = 0;
   endtask

   task automatic model_step();
      bit y1, y2, y3, y4, y5, y6, y9, mv_done_b, ax_done_b;
      y1 = cmd[0]; y2 = cmd[1]; y3 = cmd[2]; y4 = cmd[3];
      y5 = cmd[4]; y6 = cmd[5]; y9 = cmd[8];
      mv_done_b = mv_done_at(cyc - 1);
      ax_done_b = ax_done_at(cyc - 1);
      if ((y1 && y3) || (y4 && y2)) m_err = 1;
      if (m_loaded && y5) begin
         m_loaded = 0; m_attr = '0; m_cycles = (m_cycles + 1) % 256;
      end else if (m_loaded && part_in) begin
         m_err = 1;
      end else if (!m_loaded && part_in) begin
         m_loaded = 1; m_attr = attr;
      end
      if (y4) begin
         if (mv_done_b) m_mv_active = 0;
         else m_err = 1;
      end else if (!m_mv_active && y2) begin
         m_mv_active = 1; m_mv_due = cyc + MOVE;
      end
      if (y4 && !mv_done_b && !m_mv_active && y2) begin
         m_mv_active = 1; m_mv_due = cyc + MOVE;
      end
      if (ax_done_b && y2 && y3) m_ax_active = 0;
      else if (!m_ax_active && y9) begin
         m_ax_active = 1; m_ax_due = cyc + AUX;
      end
      if (y6) m_insp = insp;
      else if (y4) m_insp = '0;
   endtask

   function automatic logic [11:0] exp_sens();
      logic [11:0] s;
      s = '0;
      s[0]  = m_loaded;
      s[1]  = m_insp[1];
      s[2]  = m_insp[0];
      s[3]  = mv_done_at(cyc);
      s[4]  = m_attr[0];
      s[5]  = m_attr[1];
      s[6]  = ax_done_at(cyc);
      s[7]  = m_attr[2];
      s[8]  = m_attr[3];
      s[9]  = m_attr[4];
      s[10] = m_attr[5];
      s[11] = m_attr[6];
      return s;
   endfunction

   // One clock edge: model follows the inputs the DUT sampled, then inputs may change.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!rst) model_step();
      #2;
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      cmd = 10'h3FF; part_in = 1'b1; attr = 7'h7F; insp = 2'b11;
      tick(); tick();
      cmd = '0; part_in = 1'b0; attr = '0; insp = '0;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (running) begin
         vectors++;
         if (sens !== exp_sens() || cycles !== 8'(m_cycles) || err !== m_err) begin
            miscompares++;
            $display("FAIL cycle_cmp @%0d: sens=%h cycles=%0d err=%b expected sens=%h cycles=%0d err=%b",
                     cyc, sens, cycles, err, exp_sens(), m_cycles, m_err);
         end
      end
   end

   initial begin
      #1;
      model_reset();
      running = 1'b1;

      // Reset holds everything at zero even with all commands high.
      do_reset();
      rst = 1'b1; cmd = 10'h3FF;
      tick();
      chk("reset_sens", sens, 12'h000);
      chk("reset_err_cycles", {3'b0, err, cycles}, 12'h000);
      cmd = '0; rst = 1'b0;

      // Load, simultaneous y5+part_in, reload, double load error.
      part_in = 1'b1; attr = 7'b1100000;
      tick();
      chk("load_sens", sens, 12'hC01);
      part_in = 1'b1; cmd = 10'h010;
      tick();
      chk("y5_wins_sens", sens, 12'h000);
      chk("y5_wins_cnt_err", {3'b0, err, cycles}, 12'h001);
      attr = 7'b1100000; cmd = '0;
      tick();
      attr = 7'b0011111;
      tick();
      chk("double_load_err", {11'b0, err}, 12'h001);
      chk("double_load_attr", sens, 12'hC01);
      part_in = 1'b0;

      // Motion timing: x4 after exactly MOVE edges, y4 clears, idle y4 errs.
      do_reset();
      cmd = 10'h002;
      tick();
      cmd = '0;
      tick(); tick(); tick();
      chk("move_not_yet", {11'b0, sens[3]}, 12'h000);
      tick();
      chk("move_done", {11'b0, sens[3]}, 12'h001);
      cmd = 10'h008;
      tick();
      chk("move_clear", {10'b0, err, sens[3]}, 12'h000);
      tick();
      chk("idle_y4_err", {11'b0, err}, 12'h001);
      cmd = '0;

      // Aux timing.
      do_reset();
      cmd = 10'h100;
      tick();
      cmd = '0;
      tick(); tick();
      chk("aux_not_yet", {11'b0, sens[6]}, 12'h000);
      tick();
      chk("aux_done", {11'b0, sens[6]}, 12'h001);
      cmd = 10'h006;
      tick();
      cmd = '0;
      chk("aux_clear", {11'b0, sens[6]}, 12'h000);

      // Reset during travel kills the pending timer.
      do_reset();
      cmd = 10'h002;
      tick();
      cmd = '0;
      tick();
      rst = 1'b1; model_reset();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("rst_kills_move", {11'b0, sens[3]}, 12'h000);

      // Counter wrap after 256 part cycles.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         part_in = 1'b1; attr = 7'($urandom);
         tick();
         part_in = 1'b0; cmd = 10'h010;
         tick();
         cmd = '0;
      end
      chk("wrap_cycles_err", {3'b0, err, cycles}, 12'h000);

      // Randomized closed loop.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) do_reset();
         cmd = '0;
         for (int b = 0; b < 10; b++) cmd[b] = ($urandom_range(4) == 0);
         if ($urandom_range(9) != 0) begin
            if (cmd[0]) cmd[2] = 1'b0;
         end
         cmd[3] = mv_done_at(cyc) ? ($urandom_range(1) == 0) : ($urandom_range(49) == 0);
         if (!m_loaded) cmd[4] = 1'b0;
         if (cmd[3]) cmd[5] = 1'b0;
         part_in = ($urandom_range(5) == 0);
         attr    = 7'($urandom);
         insp    = 2'($urandom);
         tick();
      end

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
